// File: rtl/givens_rotation_apply_pkg.sv
`default_nettype none
// =============================================================================
// givens_rotation_apply_pkg : widths, Q2.30 constants, FSM encoding, saturation
// Revision: 1.0
// =============================================================================
package givens_rotation_apply_pkg;

   localparam int ROT_W        = 32;
   localparam int FRAC_DEFAULT = 30;

   localparam logic [ROT_W-1:0] ONE     = 32'h4000_0000;
   localparam logic [ROT_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [ROT_W-1:0] SAT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } ctrl_state_e;

   function automatic logic [ROT_W-1:0] sat32(input logic signed [64:0] v);
      logic signed [64:0] hi;
      logic signed [64:0] lo;
      hi = {{33{1'b0}}, SAT_MAX};
      lo = {{33{1'b1}}, SAT_MIN};
      if (v > hi)      return SAT_MAX;
      else if (v < lo) return SAT_MIN;
      else             return v[ROT_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/givens_rotation_apply_rot_fifo.sv
`default_nettype none
// =============================================================================
// givens_rotation_apply_rot_fifo : DEPTH-entry FIFO of packed {c,s} rotations
// Revision: 1.0
// =============================================================================
module givens_rotation_apply_rot_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/givens_rotation_apply.sv
`default_nettype none
// =============================================================================
// givens_rotation_apply : buffers (c,s) rotations and applies each to one (y1,y2)
// Revision: 1.0
// =============================================================================
module givens_rotation_apply
   import givens_rotation_apply_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int FRAC  = FRAC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        rot_valid,
   input  logic [31:0] rot_c,
   input  logic [31:0] rot_s,
   output logic        rot_full,
   output logic        rot_ovf,
   input  logic        vec_valid,
   output logic        vec_ready,
   input  logic [31:0] y1_in,
   input  logic [31:0] y2_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y1_out,
   output logic [31:0] y2_out
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic signed [64:0] RND = 65'sd1 <<< (FRAC - 1);

   logic [63:0]        fifo_rdata;
   logic               fifo_full, fifo_empty;
   logic [CW-1:0]      fifo_count;
   logic               push, pop, s1_adv, s2_adv, pipe_busy, last_pop;
   ctrl_state_e        state_q, state_d;
   logic               rot_ovf_q, rot_ovf_d;
   logic               s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
   logic signed [63:0] p_cy1_q, p_cy1_d, p_sy2_q, p_sy2_d;
   logic signed [63:0] p_cy2_q, p_cy2_d, p_sy1_q, p_sy1_d;
   logic [31:0]        y1_out_q, y1_out_d, y2_out_q, y2_out_d;
   logic signed [64:0] sum1, sum2;

   givens_rotation_apply_rot_fifo #(.DEPTH(DEPTH), .W(64)) u_rot_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata ({rot_c, rot_s}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign rot_full  = fifo_full;
   assign rot_ovf   = rot_ovf_q;
   assign out_valid = out_valid_q;
   assign y1_out    = y1_out_q;
   assign y2_out    = y2_out_q;

   always_comb begin
      s2_adv    = ~out_valid_q | out_ready;
      s1_adv    = ~s1_valid_q | s2_adv;
      vec_ready = ~fifo_empty & s1_adv;
      pop       = vec_valid & vec_ready;
      // Push decision uses registered fullness: a pop in the same cycle does not free the slot early.
      push      = rot_valid & ~fifo_full & ~flush;
      rot_ovf_d = flush ? 1'b0 : (rot_ovf_q | (rot_valid & fifo_full));

      s1_valid_d = s1_valid_q;
      p_cy1_d    = p_cy1_q;
      p_sy2_d    = p_sy2_q;
      p_cy2_d    = p_cy2_q;
      p_sy1_d    = p_sy1_q;
      if (s1_adv) begin
         s1_valid_d = pop;
         if (pop) begin
            p_cy1_d = $signed(fifo_rdata[63:32]) * $signed(y1_in);
            p_sy2_d = $signed(fifo_rdata[31:0])  * $signed(y2_in);
            p_cy2_d = $signed(fifo_rdata[63:32]) * $signed(y2_in);
            p_sy1_d = $signed(fifo_rdata[31:0])  * $signed(y1_in);
         end
      end

      sum1 = {p_cy1_q[63], p_cy1_q} + {p_sy2_q[63], p_sy2_q};
      sum2 = {p_cy2_q[63], p_cy2_q} - {p_sy1_q[63], p_sy1_q};

      out_valid_d = out_valid_q;
      y1_out_d    = y1_out_q;
      y2_out_d    = y2_out_q;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            y1_out_d = sat32((sum1 + RND) >>> FRAC);
            y2_out_d = sat32((sum2 + RND) >>> FRAC);
         end
      end

      if (flush) begin
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      pipe_busy = s1_valid_q | out_valid_q;
      last_pop  = (fifo_count == CW'(1)) & pop & ~push;
      case (state_q)
         ST_IDLE:  if (push) state_d = ST_RUN;
         ST_RUN: begin
            if (last_pop)                    state_d = ST_DRAIN;
            else if (fifo_empty & ~push)     state_d = pipe_busy ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            if (push)                                       state_d = ST_RUN;
            else if (out_valid_q & out_ready & ~s1_valid_q) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         rot_ovf_q   <= 1'b0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         p_cy1_q     <= '0;
         p_sy2_q     <= '0;
         p_cy2_q     <= '0;
         p_sy1_q     <= '0;
         y1_out_q    <= '0;
         y2_out_q    <= '0;
      end else begin
         state_q     <= state_d;
         rot_ovf_q   <= rot_ovf_d;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         p_cy1_q     <= p_cy1_d;
         p_sy2_q     <= p_sy2_d;
         p_cy2_q     <= p_cy2_d;
         p_sy1_q     <= p_sy1_d;
         y1_out_q    <= y1_out_d;
         y2_out_q    <= y2_out_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_givens_rotation_apply.sv
`default_nettype none
// =============================================================================
// tb_givens_rotation_apply : vector table + scoreboard bench for givens_rotation_apply
// Revision: 1.0
// =============================================================================
module tb_givens_rotation_apply;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        rot_valid = 1'b0;
   logic [31:0] rot_c = '0, rot_s = '0;
   logic        rot_full, rot_ovf;
   logic        vec_valid = 1'b0;
   logic        vec_ready;
   logic [31:0] y1_in = '0, y2_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] y1_out, y2_out;

   typedef struct {
      logic [31:0] e1;
      logic [31:0] e2;
   } exp_t;

   typedef struct {
      logic [31:0] c, s, y1, y2, e1, e2;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   int   outputs_seen = 0;
   bit   rnd_bp = 1'b0;
   exp_t exp_q[$];
   exp_t mon_e;
   vec_t tbl[8];

   givens_rotation_apply #(.DEPTH(4), .FRAC(30)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .rot_valid (rot_valid),
      .rot_c     (rot_c),
      .rot_s     (rot_s),
      .rot_full  (rot_full),
      .rot_ovf   (rot_ovf),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .y1_in     (y1_in),
      .y2_in     (y2_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y1_out    (y1_out),
      .y2_out    (y2_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Reference: a*p (+/-) b*q in wide arithmetic, round half up, shift 30, clamp to int32.
   function automatic logic [31:0] ref_rot(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] p, input logic [31:0] q,
                                           input bit sub);
      logic signed [95:0] ta, tb, tp, tq, t;
      ta = {{64{a[31]}}, a};
      tb = {{64{b[31]}}, b};
      tp = {{64{p[31]}}, p};
      tq = {{64{q[31]}}, q};
      t  = sub ? (ta * tp - tb * tq) : (ta * tp + tb * tq);
      t  = (t + 96'sd536870912) >>> 30;
      if (t > 96'sd2147483647)  return 32'h7FFF_FFFF;
      if (t < -96'sd2147483648) return 32'h8000_0000;
      return t[31:0];
   endfunction

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         outputs_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=0x%08h_%08h required=none", y1_out, y2_out);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_y1_out", y1_out, mon_e.e1);
            check("sb_y2_out", y2_out, mon_e.e2);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic push_rot(input logic [31:0] c, input logic [31:0] s);
      rot_valid = 1'b1;
      rot_c     = c;
      rot_s     = s;
      step();
      rot_valid = 1'b0;
   endtask

   task automatic send_vec(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e1, input logic [31:0] e2);
      bit   ok;
      exp_t e;
      ok        = 1'b0;
      vec_valid = 1'b1;
      y1_in     = a;
      y2_in     = b;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (vec_ready) begin
            e.e1 = e1;
            e.e2 = e2;
            exp_q.push_back(e);
            ok = 1'b1;
         end
         step();
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL vec_accept_timeout actual=not_accepted required=accepted");
         vec_valid = 1'b0;
      end
   endtask

   task automatic send_rotated(input logic [31:0] c, input logic [31:0] s,
                               input logic [31:0] a, input logic [31:0] b);
      send_vec(a, b, ref_rot(c, s, a, b, 1'b0), ref_rot(c, s, b, a, 1'b1));
   endtask

   task automatic wait_drain();
      int n;
      n         = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         step();
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      int base_out;
      logic [31:0] rc[5], rs[5];
      logic [31:0] c, s, a, b;

      tbl[0] = '{32'h4000_0000, 32'h0000_0000, 32'h0000_007B, 32'hFFFF_FFB3, 32'h0000_007B, 32'hFFFF_FFB3};
      tbl[1] = '{32'h0000_0000, 32'h4000_0000, 32'h0000_0005, 32'h0000_0009, 32'h0000_0009, 32'hFFFF_FFFB};
      tbl[2] = '{32'h4000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000};
      tbl[3] = '{32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
      tbl[4] = '{32'h2000_0000, 32'h2000_0000, 32'h0000_0003, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF};
      tbl[5] = '{32'h2000_0000, 32'h0000_0000, 32'h0000_0003, 32'hFFFF_FFFD, 32'h0000_0002, 32'hFFFF_FFFF};
      tbl[6] = '{32'hC000_0000, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFEC, 32'hFFFF_FFF6, 32'h0000_0014};
      tbl[7] = '{32'h4000_0000, 32'hC000_0000, 32'h0000_0064, 32'h0000_0032, 32'h0000_0032, 32'h0000_0096};

      // Reset values
      #12;
      check("rst_rot_full", 32'(rot_full), 0);
      check("rst_rot_ovf", 32'(rot_ovf), 0);
      check("rst_vec_ready", 32'(vec_ready), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_y1_out", y1_out, 0);
      check("rst_y2_out", y2_out, 0);
      #1 rst = 1'b1;
      step();

      // Identity with latency check
      push_rot(32'h4000_0000, 32'h0);
      send_vec(32'h0000_007B, 32'hFFFF_FFB3, 32'h0000_007B, 32'hFFFF_FFB3);
      vec_valid = 1'b0;
      @(negedge clk);
      check("latency_cycle1_out_valid", 32'(out_valid), 0);
      @(negedge clk);
      check("latency_cycle2_out_valid", 32'(out_valid), 1);
      step();
      wait_drain();

      // Table in batches of four queued rotations, back-to-back vectors
      for (int bt = 0; bt < 2; bt++) begin
         for (int k = 0; k < 4; k++) push_rot(tbl[4*bt+k].c, tbl[4*bt+k].s);
         for (int k = 0; k < 4; k++) send_vec(tbl[4*bt+k].y1, tbl[4*bt+k].y2, tbl[4*bt+k].e1, tbl[4*bt+k].e2);
         vec_valid = 1'b0;
         wait_drain();
      end

      // Overflow: five pushes into a four-deep FIFO
      for (int k = 0; k < 5; k++) begin
         rc[k] = 32'h1000_0000 * (k + 1);
         rs[k] = 32'h0100_0000 * k;
         push_rot(rc[k], rs[k]);
      end
      check("ovf_rot_full", 32'(rot_full), 1);
      check("ovf_rot_ovf", 32'(rot_ovf), 1);
      for (int k = 0; k < 4; k++) send_rotated(rc[k], rs[k], 32'd4, 32'd8);
      vec_valid = 1'b0;
      @(negedge clk);
      check("ovf_fifo_empty_vec_ready", 32'(vec_ready), 0);
      step();
      wait_drain();
      check("ovf_sticky", 32'(rot_ovf), 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_clears_ovf", 32'(rot_ovf), 0);

      // Flush on a full FIFO with a coincident rotation: dropped, no overflow
      for (int k = 0; k < 4; k++) push_rot(rc[k], rs[k]);
      check("refill_rot_full", 32'(rot_full), 1);
      flush = 1'b1;
      rot_valid = 1'b1;
      step();
      flush = 1'b0;
      rot_valid = 1'b0;
      @(negedge clk);
      check("flush_vec_ready", 32'(vec_ready), 0);
      check("flush_rot_full", 32'(rot_full), 0);
      check("flush_no_ovf", 32'(rot_ovf), 0);
      step();

      // Flush discards an in-flight result
      push_rot(32'h4000_0000, 32'h0);
      send_vec(32'd1, 32'd2, 32'd1, 32'd2);
      vec_valid = 1'b0;
      flush = 1'b1;
      exp_q.delete();
      step();
      flush = 1'b0;
      @(negedge clk);
      check("flush_discard_out_valid", 32'(out_valid), 0);
      step();

      // Back-pressure: three rotations queued, output stalled five cycles
      base_out  = outputs_seen;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) push_rot(32'h0000_0000 + 32'h1000_0000 * k, 32'h4000_0000 - 32'h1000_0000 * k);
      send_rotated(32'h0000_0000, 32'h4000_0000, 32'd11, 32'd22);
      send_rotated(32'h1000_0000, 32'h3000_0000, 32'd33, 32'd44);
      y1_in = 32'd55;
      y2_in = 32'd66;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_vec_ready", 32'(vec_ready), 0);
         check("stall_out_valid", 32'(out_valid), 1);
         check("stall_y1_held", y1_out, exp_q[0].e1);
         step();
      end
      out_ready = 1'b1;
      send_rotated(32'h2000_0000, 32'h2000_0000, 32'd55, 32'd66);
      vec_valid = 1'b0;
      wait_drain();
      check("bp_output_count", 32'(outputs_seen - base_out), 3);

      // Randomised rotations with random back-pressure
      rnd_bp = 1'b1;
      for (int k = 0; k < 24; k++) begin
         c = $urandom();
         s = $urandom();
         a = (k % 3 == 0) ? 32'h7FFF_FFF0 ^ 32'($urandom_range(0, 15)) : $urandom();
         b = $urandom();
         push_rot(c, s);
         send_rotated(c, s, a, b);
         vec_valid = 1'b0;
      end
      rnd_bp = 1'b0;
      wait_drain();

      // Reset mid-stream
      for (int k = 0; k < 4; k++) push_rot(32'h4000_0000, 32'h0100_0000 * k);
      send_rotated(32'h4000_0000, 32'h0, 32'd7, 32'd9);
      vec_valid = 1'b0;
      push_rot(32'h4000_0000, 32'h0500_0000);
      @(negedge clk);
      check("pre_rst_out_valid", 32'(out_valid), 1);
      check("pre_rst_rot_full", 32'(rot_full), 1);
      check("pre_rst_vec_ready", 32'(vec_ready), 1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 0);
      check("async_rst_rot_full", 32'(rot_full), 0);
      check("async_rst_vec_ready", 32'(vec_ready), 0);
      check("async_rst_y1_out", y1_out, 0);
      exp_q.delete();
      @(posedge clk);
      #2 rst = 1'b1;
      step();
      push_rot(32'h0000_0000, 32'h4000_0000);
      send_vec(32'd5, 32'd9, 32'd9, 32'hFFFF_FFFB);
      vec_valid = 1'b0;
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
